rr_onehot_encoder: RTL



---
 rtl/rr_onehot_encoder.sv | 68 ++++++
 1 files changed

// File: rtl/rr_onehot_encoder.sv
// rr_onehot_encoder: round-robin 32-to-5 encoder with one-hot echo and valid/ready handoff
module rr_onehot_encoder #(
    parameter int N    = 32,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    req,
    input  logic            ready,
    output logic            valid,
    output logic [IDXW-1:0] index,
    output logic [N-1:0]    onehot,
    output logic            multi
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t          state, state_n;
    logic [IDXW-1:0] ptr, ptr_n, index_n, off, pick;
    logic [N-1:0]    rot, onehot_n;
    logic            valid_n, multi_n;
    // Rotate so ptr lands at bit 0; the lowest set bit of rot is the winner's distance from ptr.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = IDXW'(i);
        pick = ptr + off;
    end
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        valid_n  = valid;
        index_n  = index;
        onehot_n = onehot;
        multi_n  = multi;
        if (state == IDLE) begin
            if (enable && req != '0) begin
                state_n  = GRANT;
                valid_n  = 1'b1;
                index_n  = pick;
                onehot_n = N'(1) << pick;
                multi_n  = (req & (req - N'(1))) != '0;
            end
        end else if (ready) begin
            state_n  = IDLE;
            valid_n  = 1'b0;
            onehot_n = '0;
            ptr_n    = index + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            valid  <= 1'b0;
            index  <= '0;
            onehot <= '0;
            multi  <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            valid  <= valid_n;
            index  <= index_n;
            onehot <= onehot_n;
            multi  <= multi_n;
        end
    end
endmodule
